// File: rtl/carry_save_adder3.sv
// Two-stage three-operand adder: a 3:2 carry-save layer is registered,
// then a carry-propagate add produces the registered sum and overflow flag.
module carry_save_adder3 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             out_valid
);

  logic [WIDTH-1:0] s_d;
  logic [WIDTH-1:0] k_d;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] k_q;
  logic             v1_q;
  logic [WIDTH+1:0] t;

  // 3:2 compression: per-bit sum and majority carry
  always_comb begin
    s_d = a ^ b ^ c;
    k_d = (a & b) | (a & c) | (b & c);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_q  <= '0;
      k_q  <= '0;
      v1_q <= 1'b0;
    end else begin
      s_q  <= s_d;
      k_q  <= k_d;
      v1_q <= in_valid;
    end
  end

  // carries weigh twice their bit position; two extra bits hold 3*(2^W-1)
  assign t = {2'b00, s_q} + {1'b0, k_q, 1'b0};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      z         <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      z         <= t[WIDTH-1:0];
      cout      <= |t[WIDTH+1:WIDTH];
      out_valid <= v1_q;
    end
  end

endmodule

// File: tb/tb_carry_save_adder3.sv
// Self-checking bench for carry_save_adder3: table vectors, reset corner
// cases and a randomized stream against an arithmetic reference model.
module tb_carry_save_adder3;
  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] a, b, c;
  logic [W-1:0] z;
  logic         cout;
  logic         out_valid;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic         v;
    logic [W-1:0] z;
    logic         co;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic         v;
    logic [W-1:0] z;
    logic         co;
  } vec_t;

  exp_t pipe[$];
  vec_t tbl[13];

  carry_save_adder3 #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .a(a), .b(b), .c(c),
    .z(z), .cout(cout), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  // After reset release the stage-1 registers hold cleared, invalid data.
  task automatic restart_model();
    exp_t e0;
    e0.v = 1'b0; e0.z = '0; e0.co = 1'b0;
    pipe.delete();
    pipe.push_back(e0);
  endtask

  // Called at a falling edge: drive inputs, run one rising edge, then
  // compare outputs with the record pushed two edges earlier.
  task automatic step(input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic [W-1:0] ic, input logic iv,
                      input logic [W-1:0] ez, input logic ec);
    exp_t e;
    a = ia; b = ib; c = ic; in_valid = iv;
    e.v = iv; e.z = ez; e.co = ec;
    pipe.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (pipe.size() >= 2) begin
      e = pipe.pop_front();
      chk("out_valid", int'(out_valid), int'(e.v));
      if (e.v) begin
        chk("z", int'(z), int'(e.z));
        chk("cout", int'(cout), int'(e.co));
      end
    end
  endtask

  task automatic rand_step();
    logic [W-1:0] ra, rb, rc;
    logic         rv;
    int           sum;
    ra = W'($urandom); rb = W'($urandom); rc = W'($urandom);
    rv = 1'($urandom_range(0, 1));
    sum = int'(ra) + int'(rb) + int'(rc);
    step(ra, rb, rc, rv, W'(sum % (1 << W)), sum >= (1 << W));
  endtask

  task automatic hold_reset(input int n);
    for (int i = 0; i < n; i++) begin
      a = W'($urandom); b = W'($urandom); c = W'($urandom);
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      chk("rst_z", int'(z), 0);
      chk("rst_cout", int'(cout), 0);
      chk("rst_out_valid", int'(out_valid), 0);
    end
  endtask

  initial begin
    clk = 1'b0; reset = 1'b0; in_valid = 1'b0;
    a = '0; b = '0; c = '0;

    tbl[0]  = '{a: 1,   b: 1,   c: 1,   v: 1, z: 3,   co: 0};
    tbl[1]  = '{a: 45,  b: 72,  c: 56,  v: 1, z: 173, co: 0};
    tbl[2]  = '{a: 66,  b: 62,  c: 48,  v: 1, z: 176, co: 0};
    tbl[3]  = '{a: 92,  b: 85,  c: 74,  v: 1, z: 251, co: 0};
    tbl[4]  = '{a: 12,  b: 27,  c: 143, v: 1, z: 182, co: 0};
    tbl[5]  = '{a: 128, b: 128, c: 0,   v: 1, z: 0,   co: 1};
    tbl[6]  = '{a: 200, b: 100, c: 0,   v: 1, z: 44,  co: 1};
    tbl[7]  = '{a: 255, b: 255, c: 255, v: 1, z: 253, co: 1};
    tbl[8]  = '{a: 255, b: 0,   c: 0,   v: 1, z: 255, co: 0};
    tbl[9]  = '{a: 1,   b: 2,   c: 3,   v: 1, z: 6,   co: 0};
    tbl[10] = '{a: 9,   b: 9,   c: 9,   v: 0, z: 0,   co: 0};
    tbl[11] = '{a: 4,   b: 5,   c: 6,   v: 1, z: 15,  co: 0};
    tbl[12] = '{a: 0,   b: 0,   c: 0,   v: 0, z: 0,   co: 0};

    @(negedge clk);
    hold_reset(4);
    reset = 1'b1;
    restart_model();

    for (int i = 0; i < 13; i++)
      step(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].v, tbl[i].z, tbl[i].co);
    step(0, 0, 0, 0, 0, 0);

    // Mid-stream reset with two results in flight.
    step(10, 20, 30, 1, 60, 0);
    step(100, 100, 100, 1, 44, 1);
    chk("pre_rst_out_valid", int'(out_valid), 1);
    #1 reset = 1'b0;
    #1;
    chk("async_z", int'(z), 0);
    chk("async_cout", int'(cout), 0);
    chk("async_out_valid", int'(out_valid), 0);
    @(negedge clk);
    hold_reset(2);
    reset = 1'b1;
    restart_model();
    step(7, 7, 7, 0, 0, 0);
    step(7, 7, 7, 0, 0, 0);
    step(50, 60, 70, 1, 180, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 1000; i++)
      rand_step();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/carry_save_adder3.md
Name: carry_save_adder3

Overview:
- Pipelined three-operand adder: adds unsigned WIDTH-bit operands a, b and c.
- Stage 1 is a carry-save (3:2 compressor) layer. Stage 2 is a carry-propagate adder.
- z is the WIDTH-bit modular sum; cout flags any overflow beyond WIDTH bits.
- Used wherever three vectors must be summed in one pass, e.g. accumulation or multiplier partial-product reduction.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range ≥ 2).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- in_valid  input  1  a/b/c are valid this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- c  input  WIDTH  operand C, unsigned.
- z  output  WIDTH  registered sum, (a+b+c) mod 2^WIDTH.
- cout  output  1  registered overflow flag; 1 when a+b+c ≥ 2^WIDTH.
- out_valid  output  1  z/cout hold a valid result this cycle.

Behaviour:
- Reset:
  - When reset goes low, all pipeline registers clear immediately, independent of clk.
  - During reset: z=0, cout=0, out_valid=0.
  - Reset applied mid-operation discards every in-flight result; no result emerges after release.
- Stage 1, on each rising edge with reset high:
  - Per bit i: s[i] = a[i]^b[i]^c[i]; k[i] = maj(a[i],b[i],c[i]), i.e. (a&b)|(a&c)|(b&c).
  - s (WIDTH bits), k (WIDTH bits) and v1 = in_valid are registered.
- Stage 2, on each rising edge:
  - t = {2'b00,s} + {1'b0,k,1'b0}, computed at WIDTH+2 bits.
  - z <= t[WIDTH-1:0].
  - cout <= |t[WIDTH+1:WIDTH].
  - out_valid <= v1.
- Latency:
  - Exactly 2 clock edges: inputs sampled at edge n appear on z/cout/out_valid after edge n+1.
  - Throughput is one result per cycle.
  - No back-pressure; the pipeline never stalls.
- Invalid inputs: when in_valid=0 the datapath still computes and registers results. z/cout then carry don't-care data; consumers qualify them with out_valid.
- Arithmetic:
  - Operands are unsigned and the sum is exact mod 2^WIDTH.
  - cout is an overflow indicator, not a single carry bit. Maximum true sum is 3·(2^WIDTH−1), which needs WIDTH+2 bits.
  - Commutative: any permutation of a/b/c gives identical z/cout.
- No combinational path from inputs to outputs. Outputs change only on clk edges or reset assertion.

Test Plan:
- Reset: hold reset=0 over several clk edges with random operands -> z=0, cout=0, out_valid=0 throughout. Release reset, apply a=1, b=1, c=1, in_valid=1 -> z=3, cout=0, out_valid=1 two edges later.
- No-overflow stream, back-to-back, in_valid=1:
  - (45,72,56) -> 173, cout 0.
  - (66,62,48) -> 176, cout 0.
  - (92,85,74) -> 251, cout 0.
  - (12,27,143) -> 182, cout 0.
  - Each result arrives 2 edges after its inputs, on consecutive cycles.
- Overflow boundaries:
  - (128,128,0) -> z=0, cout=1.
  - (200,100,0) -> z=44, cout=1.
  - (255,255,255) -> z=253, cout=1.
  - (255,0,0) -> z=255, cout=0.
- Valid gating: toggle in_valid 1,0,1 with operands (1,2,3),(9,9,9),(4,5,6) -> out_valid 1,0,1 two edges later; valid results z=6 and z=15.
- Mid-stream reset: assert reset asynchronously between edges while two results are in flight -> outputs clear immediately. After release, out_valid stays 0 until new valid inputs have propagated 2 edges.
- Randomized: 1000 random (a,b,c) with random in_valid -> z/cout match the golden model (a+b+c) mod 256 and (a+b+c)≥256, delayed 2 cycles.
